// File: rtl/io_cfg_seq_if.sv
// Register-bus bundle for io_cfg_seq: management side drives the request,
// the sequencer returns read data and a one-cycle acknowledge.
interface io_cfg_seq_if #(
  parameter int unsigned CFG_W  = 13,
  parameter int unsigned ADDR_W = 6
);
  logic              reg_cs;
  logic              reg_wr;
  logic [ADDR_W-1:0] reg_addr;
  logic [CFG_W-1:0]  reg_wdata;
  logic [CFG_W-1:0]  reg_rdata;
  logic              reg_ack;

  modport master (
    output reg_cs, reg_wr, reg_addr, reg_wdata,
    input  reg_rdata, reg_ack
  );

  modport slave (
    input  reg_cs, reg_wr, reg_addr, reg_wdata,
    output reg_rdata, reg_ack
  );
endinterface

// File: rtl/io_cfg_seq.sv
// Pad configuration sequencer: per-pad config bank behind a register bus, shifted
// out MSB-first from the top pad down, then latched with ser_load.
// Optional IO_CFG_AUTO_START_EN: self-start one sequence right after reset release.
module io_cfg_seq #(
  parameter int unsigned       NUM_PADS = 38,
  parameter int unsigned       CFG_W    = 13,
  parameter int unsigned       CLK_DIV  = 4,
  parameter logic [CFG_W-1:0]  CFG_RST  = CFG_W'(13'h0403)
) (
  input  logic         mclk,
  input  logic         reset_n,
  io_cfg_seq_if.slave  bus,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         ser_clk,
  output logic         ser_data,
  output logic         ser_load
);

  localparam int unsigned PAD_W = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1;
  localparam int unsigned BIT_W = (CFG_W > 1)    ? $clog2(CFG_W)    : 1;
  localparam int unsigned DIV_W = (CLK_DIV > 1)  ? $clog2(CLK_DIV)  : 1;

  localparam logic [PAD_W-1:0] PAD_LAST = PAD_W'(NUM_PADS - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CFG_W - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_LOAD,
    S_DONE
  } state_t;

  state_t             state_q, state_n;
  logic [DIV_W-1:0]   div_q, div_n;
  logic [BIT_W-1:0]   bit_q, bit_n;
  logic [PAD_W-1:0]   pad_q, pad_n;
  logic [CFG_W-1:0]   word_q, word_n;
  logic               ser_data_n;
  logic               start_eff;

  logic [CFG_W-1:0]   bank [NUM_PADS];
  logic               cs_q;
  logic               acc;
  logic               addr_ok;
  logic [PAD_W-1:0]   addr_idx;

`ifdef IO_CFG_AUTO_START_EN
  // One-shot armed during reset, fires on the first cycle out of reset
  logic auto_q;

  always_ff @(posedge mclk) begin
    if (!reset_n) auto_q <= 1'b1;
    else          auto_q <= 1'b0;
  end

  assign start_eff = start | auto_q;
`else
  assign start_eff = start;
`endif

  // Register bus: ack once per rising edge of reg_cs
  assign acc      = bus.reg_cs & ~cs_q;
  assign addr_ok  = 32'(bus.reg_addr) < NUM_PADS;
  assign addr_idx = PAD_W'(bus.reg_addr);

  always_ff @(posedge mclk) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_PADS; i++) begin
        bank[PAD_W'(i)] <= CFG_RST;
      end
      cs_q          <= 1'b0;
      bus.reg_ack   <= 1'b0;
      bus.reg_rdata <= '0;
    end else begin
      cs_q        <= bus.reg_cs;
      bus.reg_ack <= acc;
      if (acc) begin
        bus.reg_rdata <= addr_ok ? bank[addr_idx] : '0;
      end
      // Bank is frozen while a sequence runs so the chain sees a coherent image
      if (acc && bus.reg_wr && addr_ok && !busy) begin
        bank[addr_idx] <= bus.reg_wdata;
      end
    end
  end

  // Sequencer state and registered chain outputs
  always_ff @(posedge mclk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      pad_q    <= '0;
      word_q   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ser_clk  <= 1'b0;
      ser_data <= 1'b0;
      ser_load <= 1'b0;
    end else begin
      state_q  <= state_n;
      div_q    <= div_n;
      bit_q    <= bit_n;
      pad_q    <= pad_n;
      word_q   <= word_n;
      busy     <= (state_n != S_IDLE);
      done     <= (state_n == S_DONE);
      ser_clk  <= (state_n == S_SHIFT_HI);
      ser_data <= ser_data_n;
      ser_load <= (state_n == S_LOAD);
    end
  end

  // Next-state: each phase lasts CLK_DIV cycles, counters stop at zero
  always_comb begin
    state_n    = state_q;
    div_n      = div_q;
    bit_n      = bit_q;
    pad_n      = pad_q;
    word_n     = word_q;
    ser_data_n = ser_data;

    unique case (state_q)
      S_IDLE: begin
        if (start_eff) begin
          state_n    = S_SHIFT_LO;
          div_n      = DIV_LAST;
          pad_n      = PAD_LAST;
          bit_n      = BIT_LAST;
          word_n     = bank[PAD_LAST];
          ser_data_n = word_n[BIT_LAST];
        end
      end

      S_SHIFT_LO: begin
        if (div_q == '0) begin
          state_n = S_SHIFT_HI;
          div_n   = DIV_LAST;
        end else begin
          div_n = div_q - DIV_W'(1);
        end
      end

      S_SHIFT_HI: begin
        if (div_q != '0) begin
          div_n = div_q - DIV_W'(1);
        end else begin
          div_n = DIV_LAST;
          if (bit_q != '0) begin
            state_n    = S_SHIFT_LO;
            bit_n      = bit_q - BIT_W'(1);
            ser_data_n = word_q[bit_n];
          end else if (pad_q != '0) begin
            // Next pad's word is captured on its first low phase
            state_n    = S_SHIFT_LO;
            pad_n      = pad_q - PAD_W'(1);
            bit_n      = BIT_LAST;
            word_n     = bank[pad_n];
            ser_data_n = word_n[BIT_LAST];
          end else begin
            state_n = S_LOAD;
          end
        end
      end

      S_LOAD: begin
        if (div_q == '0) begin
          state_n = S_DONE;
        end else begin
          div_n = div_q - DIV_W'(1);
        end
      end

      S_DONE: begin
        state_n = S_IDLE;
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_io_cfg_seq.sv
// Directed bench for io_cfg_seq: register bank access, chain shift contents,
// sequence length, busy write-protection, start filtering and mid-run reset.
module tb_io_cfg_seq;

  localparam int SEQ_LEN = 3957;
  localparam int BITS    = 494;

  logic mclk    = 1'b0;
  logic reset_n = 1'b0;
  logic start   = 1'b0;
  logic busy, done, ser_clk, ser_data, ser_load;

  int total = 0;
  int bad   = 0;

  io_cfg_seq_if bus ();

  io_cfg_seq dut (
    .mclk     (mclk),
    .reset_n  (reset_n),
    .bus      (bus),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .ser_clk  (ser_clk),
    .ser_data (ser_data),
    .ser_load (ser_load)
  );

  always #5 mclk = ~mclk;

  // Chain monitor: capture data on every ser_clk rise, count strobes
  int   rises         = 0;
  int   dones         = 0;
  int   loads         = 0;
  int   rises_at_load = 0;
  logic clk_prev      = 1'b0;
  logic load_prev     = 1'b0;
  logic cap [$];

  always @(negedge mclk) begin
    if (ser_clk && !clk_prev) begin
      rises = rises + 1;
      cap.push_back(ser_data);
    end
    if (ser_load && !load_prev) rises_at_load = rises;
    if (done) dones = dones + 1;
    if (ser_load) loads = loads + 1;
    clk_prev  = ser_clk;
    load_prev = ser_load;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_xfer(input logic wr, input logic [5:0] addr, input logic [12:0] wdata,
                          output logic [12:0] rdata, output int lat, output logic ack_after);
    bus.reg_cs    = 1'b1;
    bus.reg_wr    = wr;
    bus.reg_addr  = addr;
    bus.reg_wdata = wdata;
    lat = 0;
    do begin
      @(negedge mclk);
      lat++;
    end while (!bus.reg_ack && lat < 20);
    rdata = bus.reg_rdata;
    bus.reg_cs = 1'b0;
    @(negedge mclk);
    ack_after = bus.reg_ack;
  endtask

  task automatic rd_chk(input string tag, input logic [5:0] addr, input logic [12:0] exp);
    logic [12:0] d;
    int          lat;
    logic        ack_after;
    bus_xfer(1'b0, addr, 13'h0, d, lat, ack_after);
    check({tag, "_lat"}, 32'(lat), 32'd1);
    check(tag, 32'(d), 32'(exp));
    check({tag, "_ack1"}, 32'(ack_after), 32'd0);
  endtask

  task automatic wr_chk(input string tag, input logic [5:0] addr, input logic [12:0] data);
    logic [12:0] d;
    int          lat;
    logic        ack_after;
    bus_xfer(1'b1, addr, data, d, lat, ack_after);
    check({tag, "_lat"}, 32'(lat), 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge mclk);
    start = 1'b0;
  endtask

  // Called on the first negedge after the start edge; n counts cycles since start
  task automatic wait_done(output int n);
    n = 1;
    while (!done && n < 5000) begin
      @(negedge mclk);
      n++;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    check({tag, "_busy"},  32'(busy),          32'd0);
    check({tag, "_done"},  32'(done),          32'd0);
    check({tag, "_sclk"},  32'(ser_clk),       32'd0);
    check({tag, "_sdata"}, 32'(ser_data),      32'd0);
    check({tag, "_sload"}, 32'(ser_load),      32'd0);
    check({tag, "_ack"},   32'(bus.reg_ack),   32'd0);
    check({tag, "_rdata"}, 32'(bus.reg_rdata), 32'd0);
  endtask

  initial begin
    int          n;
    int          r0;
    int          d0;
    int          l0;
    int          acks;
    logic [12:0] w;

    bus.reg_cs    = 1'b0;
    bus.reg_wr    = 1'b0;
    bus.reg_addr  = 6'd0;
    bus.reg_wdata = 13'h0;

    // Reset state
    repeat (3) @(negedge mclk);
    chk_all_zero("rst");
    reset_n = 1'b1;
    @(negedge mclk);
`ifdef IO_CFG_AUTO_START_EN
    check("auto_busy", 32'(busy), 32'd1);
    wait_done(n);
    check("auto_len", 32'(n), 32'(SEQ_LEN));
    @(negedge mclk);
`endif
    check("idle_busy", 32'(busy), 32'd0);

    // Every pad holds the reset word; out-of-range reads return zero
    for (int a = 0; a < 38; a++) rd_chk($sformatf("rd_rst%0d", a), 6'(a), 13'h0403);
    rd_chk("rd_addr40", 6'd40, 13'h0000);
    wr_chk("wr_addr40", 6'd40, 13'h1234);
    rd_chk("rd_addr40b", 6'd40, 13'h0000);

    // Holding reg_cs yields a single ack
    bus.reg_cs   = 1'b1;
    bus.reg_wr   = 1'b0;
    bus.reg_addr = 6'd3;
    acks = 0;
    repeat (4) begin
      @(negedge mclk);
      if (bus.reg_ack) acks++;
    end
    bus.reg_cs = 1'b0;
    @(negedge mclk);
    check("hold_cs_acks", 32'(acks), 32'd1);

    // Shift contents and sequence length
    wr_chk("wr_p0", 6'd0, 13'h1FFF);
    wr_chk("wr_p37", 6'd37, 13'h0001);
    rd_chk("rd_p37", 6'd37, 13'h0001);
    r0 = rises;
    l0 = loads;
    pulse_start();
    check("seq1_busy", 32'(busy), 32'd1);
    wait_done(n);
    check("seq1_len", 32'(n), 32'(SEQ_LEN));
    check("seq1_done", 32'(done), 32'd1);
    check("seq1_rises", 32'(rises - r0), 32'(BITS));
    check("seq1_rises_at_load", 32'(rises_at_load - r0), 32'(BITS));
    check("seq1_load_cycles", 32'(loads - l0), 32'd4);
    if (rises - r0 >= BITS) begin
      w = '0;
      for (int i = 0; i < 13; i++) w = {w[11:0], cap[r0 + i]};
      check("seq1_first_word", 32'(w), 32'h0001);
      w = '0;
      for (int i = 13; i < 26; i++) w = {w[11:0], cap[r0 + i]};
      check("seq1_second_word", 32'(w), 32'h0403);
      w = '0;
      for (int i = BITS - 13; i < BITS; i++) w = {w[11:0], cap[r0 + i]};
      check("seq1_last_word", 32'(w), 32'h1FFF);
    end
    @(negedge mclk);
    check("seq1_done_pulse", 32'(done), 32'd0);
    check("seq1_busy_fall", 32'(busy), 32'd0);

    // Writes during busy are dropped; extra starts are ignored
    r0 = rises;
    d0 = dones;
    pulse_start();
    repeat (8) @(negedge mclk);
    pulse_start();
    wr_chk("wr_p5_busy", 6'd5, 13'h0AAA);
    rd_chk("rd_p5_busy", 6'd5, 13'h0403);
    repeat (480) @(negedge mclk);
    pulse_start();
    wait_done(n);
    check("seq2_done", 32'(done), 32'd1);
    repeat (20) @(negedge mclk);
    check("seq2_one_done", 32'(dones - d0), 32'd1);
    check("seq2_rises_at_load", 32'(rises_at_load - r0), 32'(BITS));
    check("seq2_idle", 32'(busy), 32'd0);
    rd_chk("rd_p5_after", 6'd5, 13'h0403);
    rd_chk("rd_p0_after", 6'd0, 13'h1FFF);

    // Reset in the middle of a high phase aborts the run
    d0 = dones;
    pulse_start();
    repeat (100) @(negedge mclk);
    n = 0;
    while (!ser_clk && n < 12) begin
      @(negedge mclk);
      n++;
    end
    check("mid_sclk_hi", 32'(ser_clk), 32'd1);
    l0 = loads;
    reset_n = 1'b0;
    @(negedge mclk);
    chk_all_zero("midrst");
    repeat (3) @(negedge mclk);
    reset_n = 1'b1;
    repeat (2) @(negedge mclk);
    check("midrst_no_load", 32'(loads - l0), 32'd0);
    check("midrst_no_done", 32'(dones - d0), 32'd0);
`ifdef IO_CFG_AUTO_START_EN
    wait_done(n);
    @(negedge mclk);
`endif
    for (int a = 0; a < 38; a++) rd_chk($sformatf("rd_rst2_%0d", a), 6'(a), 13'h0403);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
